spi_cmd_ctrl: RTL

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: parses write/read burst frames from an SPI byte
// interface and turns them into single-cycle video-RAM strobes.
module spi_cmd_ctrl #(
    parameter int         ADDR_W = 12,
    parameter logic [7:0] CMD_WR = 8'h01,
    parameter logic [7:0] CMD_RD = 8'h02
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_spi_cs_l,
    output logic              o_spi_cs,
    output logic              o_spi_re,
    output logic              o_spi_we,
    output logic [7:0]        o_spi_wdata,
    input  logic [7:0]        i_spi_rdata,
    input  logic              i_spi_rx_ready,
    input  logic              i_spi_rx_error,
    input  logic              i_spi_tx_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_busy,
    output logic [7:0]        o_err_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_H,
        S_ADDR_L,
        S_WR_DATA,
        S_RD_FETCH,
        S_RD_WAIT,
        S_RD_LOAD,
        S_DISCARD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              cs_sync_p0;
    logic              cs_sync_p1;
    logic              sync_vld_p0;
    logic              sync_vld_p1;
    logic              armed;
    logic              cs_act;
    logic              pop_c;
    logic              pop_d;
    logic              spi_we_c;
    logic              mem_re_c;
    logic              bad_cmd;
    logic              err_rx;
    logic              is_rd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        prefetch;
    logic [1:0]        err_inc;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign cs_act = ~cs_sync_p1;
    assign err_rx = i_spi_rx_error & cs_act;
    assign err_inc = {1'b0, err_rx} + {1'b0, bad_cmd};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pop arbitration and combinational strobes
    always_comb begin
        state_nxt = state;
        spi_we_c  = 1'b0;
        mem_re_c  = 1'b0;
        bad_cmd   = 1'b0;
        // A transmit load takes the cycle; the pending byte is popped next cycle instead.
        pop_c = (state != S_IDLE) && cs_act && i_spi_rx_ready && !pop_d &&
                !((state == S_RD_LOAD) && i_spi_tx_ready);
        case (state)
            S_IDLE: begin
                if (cs_act && armed) state_nxt = S_CMD;
            end
            S_CMD: begin
                if (pop_c) begin
                    if ((i_spi_rdata == CMD_WR) || (i_spi_rdata == CMD_RD)) begin
                        state_nxt = S_ADDR_H;
                    end else begin
                        state_nxt = S_DISCARD;
                        bad_cmd   = 1'b1;
                    end
                end
            end
            S_ADDR_H: begin
                if (pop_c) state_nxt = S_ADDR_L;
            end
            S_ADDR_L: begin
                if (pop_c) state_nxt = is_rd ? S_RD_FETCH : S_WR_DATA;
            end
            S_RD_FETCH: begin
                mem_re_c  = 1'b1;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_nxt = S_RD_LOAD;
            end
            S_RD_LOAD: begin
                if (i_spi_tx_ready) begin
                    spi_we_c  = 1'b1;
                    state_nxt = S_RD_FETCH;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
        if (!cs_act && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            spi_we_c  = 1'b0;
            mem_re_c  = 1'b0;
            bad_cmd   = 1'b0;
        end
    end

    // Synchronizer, frame parsing registers and write pipeline
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_sync_p0  <= 1'b1;
            cs_sync_p1  <= 1'b1;
            sync_vld_p0 <= 1'b0;
            sync_vld_p1 <= 1'b0;
            armed       <= 1'b0;
            pop_d       <= 1'b0;
            is_rd       <= 1'b0;
            addr        <= '0;
            prefetch    <= 8'd0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= 8'd0;
            o_err_cnt   <= 8'd0;
        end else begin
            cs_sync_p0  <= i_spi_cs_l;
            cs_sync_p1  <= cs_sync_p0;
            sync_vld_p0 <= 1'b1;
            sync_vld_p1 <= sync_vld_p0;
            // Only a genuinely observed idle bus arms the parser, so a frame
            // already running when reset drops is ignored to its end.
            if (sync_vld_p1 && !cs_act) armed <= 1'b1;
            pop_d    <= pop_c;
            o_mem_we <= pop_c && (state == S_WR_DATA);
            if (pop_c && (state == S_WR_DATA)) o_mem_wdata <= i_spi_rdata;
            if (pop_c && (state == S_CMD)) is_rd <= (i_spi_rdata == CMD_RD);
            if (pop_c && (state == S_ADDR_H)) addr[ADDR_W-1:8] <= i_spi_rdata[ADDR_W-9:0];
            if (pop_c && (state == S_ADDR_L)) addr[7:0] <= i_spi_rdata;
            if (o_mem_we || spi_we_c) addr <= addr + 1'b1;
            if (state == S_RD_WAIT) prefetch <= i_mem_rdata;
            o_err_cnt <= sat_add(o_err_cnt, err_inc);
        end
    end

    assign o_spi_re    = pop_c;
    assign o_spi_we    = spi_we_c;
    assign o_spi_cs    = pop_c | spi_we_c;
    assign o_spi_wdata = prefetch;
    assign o_mem_re    = mem_re_c;
    assign o_mem_addr  = addr;
    assign o_busy      = (state != S_IDLE);

endmodule
